multicycle_ctrl_fsm: RTL

- Sequencing controller for the multi-cycle RV32I core variant. One shared ALU and one unified instruction/data memory port.
- Reads the latched instruction register each cycle and steps the datapath through fetch, decode, execute, memory and writeback states.
- Stalls on memory handshakes and counts retired instructions.
- Supported set: lw, sw, addi/slti/andi/ori, beq/bne/blt/bge/bltu/bgeu, jal, jalr.

---
 rtl/multicycle_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Sequencing controller for the multi-cycle RV32I core (shared ALU, unified
//   instruction/data memory port). Walks the datapath through fetch, decode,
//   execute, memory and writeback. It stalls on the memory handshake and
//   counts retired instructions.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   instr         : latched instruction register (valid from DECODE onward)
//   mem_ready     : memory completes the current read/write this cycle
//   branch_taken  : external comparator result for the current branch
//   PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite : datapath strobes
//   ALUsrcA, ALUsrcB, ALUctrl, ImmSrc, ResultSrc          : datapath selects
//   halted        : sticky illegal-instruction flag
//   instret       : retired instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ALUsrcA,
  output logic [1:0]            ALUsrcB,
  output logic [2:0]            ALUctrl,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            ResultSrc,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR_ADR,
    S_JALR_PC,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] instret_reg;
  logic                  halted_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       retire;

  // Raw (ungated) strobes; reset masks them below.
  logic pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Register indices and immediate bits belong to the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

  // -------------------------------------------------------------------------
  // State, retire counter and sticky halt flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire)
        instret_reg <= instret_reg + 1'b1;
      if (state_next == S_HALT)
        halted_reg <= 1'b1;
    end
  end

  // An instruction retires on its final transition back to FETCH.
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEM_WB, S_ALU_WB, S_BRANCH: retire = 1'b1;
      S_MEM_WR:                     retire = mem_ready;
      default:                      retire = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ALUsrcA       = 2'b00;
    ALUsrcB       = 2'b00;
    ALUctrl       = 3'b000;
    ImmSrc        = 2'b00;
    ResultSrc     = 2'b00;

    case (state_reg)
      S_FETCH: begin
        // PC+4 goes straight from the ALU to the PC as the word arrives.
        mem_read_raw = 1'b1;
        ALUsrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        if (mem_ready)
          state_next = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively compute OldPC+imm so ALUOut holds a branch/jal target.
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        if (opcode == OP_BRANCH)
          ImmSrc = 2'b10;
        else if (opcode == OP_JAL)
          ImmSrc = 2'b11;
        case (opcode)
          OP_LOAD, OP_STORE:
            state_next = (funct3 == 3'b010) ? S_MEM_ADR : S_HALT;
          OP_IMM:
            state_next = (funct3 == 3'b000 || funct3 == 3'b010 ||
                          funct3 == 3'b110 || funct3 == 3'b111) ? S_EXEC_I : S_HALT;
          OP_BRANCH:
            state_next = (funct3 == 3'b010 || funct3 == 3'b011) ? S_HALT : S_BRANCH;
          OP_JAL:
            state_next = S_JAL;
          OP_JALR:
            state_next = (funct3 == 3'b000) ? S_JALR_ADR : S_HALT;
          default:
            state_next = S_HALT;
        endcase
      end

      S_MEM_ADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        // Only lw and sw reach here; opcode bit 5 separates them.
        ImmSrc     = opcode[5] ? 2'b01 : 2'b00;
        state_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read_raw = 1'b1;
        AdrSrc       = 1'b1;
        if (mem_ready)
          state_next = S_MEM_WB;
      end

      S_MEM_WB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write_raw = 1'b1;
        AdrSrc        = 1'b1;
        if (mem_ready)
          state_next = S_FETCH;
      end

      S_EXEC_I: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        case (funct3)
          3'b010:  ALUctrl = 3'b101;  // slti
          3'b110:  ALUctrl = 3'b011;  // ori
          3'b111:  ALUctrl = 3'b010;  // andi
          default: ALUctrl = 3'b000;  // addi
        endcase
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        // ALU does rs1-rs2 for flags; PC takes the target held in ALUOut.
        ALUsrcA      = 2'b10;
        ALUctrl      = 3'b001;
        pc_write_raw = branch_taken;
        state_next   = S_FETCH;
      end

      S_JAL, S_JALR_PC: begin
        // PC <= target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUsrcA      = 2'b01;
        ALUsrcB      = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = S_ALU_WB;
      end

      S_JALR_ADR: begin
        ALUsrcA    = 2'b10;
        ALUsrcB    = 2'b01;
        state_next = S_JALR_PC;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  // Reset is asynchronous, so the strobes are masked combinationally to make
  // e.g. an in-flight MemWrite drop in the same cycle rst rises.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign MemRead  = mem_read_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign RegWrite = reg_write_raw & ~rst;

  assign halted  = halted_reg;
  assign instret = instret_reg;

endmodule
